// File: rtl/tick_countdown_pkg.sv
// Shared types and constants for the two-digit BCD countdown.
// States, digit width and active-low {g,f,e,d,c,b,a} segment patterns.
package tick_countdown_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_e;

  typedef struct packed {
    digit_t tens;
    digit_t ones;
  } bcd2_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic bcd_valid(
    input bcd2_t v
  );
    return (v.tens <= digit_t'(9)) &&
           (v.ones <= digit_t'(9));
  endfunction

endpackage

// File: rtl/tick_countdown_seg7_decode.sv
// seg7_decode: one BCD digit to active-low segments {g,f,e,d,c,b,a}.
// Ports: bcd (4-bit digit in), seg (7-bit segments out). Combinational.
module seg7_decode
  import tick_countdown_pkg::*;
(
  input  logic [DIGIT_W-1:0] bcd,
  output logic [6:0]         seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/tick_countdown.sv
// Two-digit BCD down-counter stepped by a divider tick, with
// start/pause/load control, terminal-count pulse and 7-seg outputs.
// Ports: clki, rst (async high), tick, start, pause, load, load_val,
// bcd_tens/bcd_ones, seg_tens/seg_ones (active low), running, done.
module tick_countdown
  import tick_countdown_pkg::*;
#(
  parameter logic [7:0] START_VAL   = 8'h09,
  parameter bit         AUTO_RELOAD = 1'b0
) (
  input  logic       clki,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_ones,
  output logic       running,
  output logic       done
);

  state_e state_q, state_d;
  bcd2_t  count_q, count_d;
  bcd2_t  reload_q, reload_d;
  logic   done_q, done_d;

  bcd2_t  dec_val;
  logic   load_ok;

  // BCD decrement: ones borrow from tens.
  always_comb begin
    dec_val = count_q;
    if (count_q.ones == '0) begin
      dec_val.ones = digit_t'(9);
      dec_val.tens = count_q.tens - digit_t'(1);
    end else begin
      dec_val.ones = count_q.ones - digit_t'(1);
    end
  end

  assign load_ok = load && bcd_valid(bcd2_t'(load_val));

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (load_ok) begin
          count_d  = bcd2_t'(load_val);
          reload_d = bcd2_t'(load_val);
        end
        // start sees the value just loaded, if any
        if (start) begin
          if (count_d == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (pause) begin
          state_d = ST_PAUSED;
        end else if (tick) begin
          // 00 in RUN only happens after an auto-reload
          // terminal count: this tick restores the value.
          if (count_q == '0) begin
            count_d = reload_q;
          end else begin
            count_d = dec_val;
            if (dec_val == '0) begin
              done_d = 1'b1;
              if (!AUTO_RELOAD) begin
                state_d = ST_IDLE;
              end
            end
          end
        end
      end
      ST_PAUSED: begin
        if (start) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= bcd2_t'(START_VAL);
      reload_q <= bcd2_t'(START_VAL);
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign bcd_tens = count_q.tens;
  assign bcd_ones = count_q.ones;
  assign running  = (state_q == ST_RUN);
  assign done     = done_q;

  seg7_decode u_seg_tens (
    .bcd (count_q.tens),
    .seg (seg_tens)
  );

  seg7_decode u_seg_ones (
    .bcd (count_q.ones),
    .seg (seg_ones)
  );

endmodule

// File: tb/tb_tick_countdown.sv
// Bench for tick_countdown: two instances (AUTO_RELOAD 0 and 1)
// share stimulus and are compared every cycle to an integer model.
module tb_tick_countdown;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;

  logic [3:0] bt [2];
  logic [3:0] bo [2];
  logic [6:0] st [2];
  logic [6:0] so [2];
  logic       rn [2];
  logic       dn [2];

  int checks = 0;
  int errors = 0;

  // model: count as plain integer 0..99, state 0 idle 1 run 2 paused
  int mcnt [2];
  int mrel [2];
  int mst  [2];
  bit mdone [2];
  int dpulses = 0;

  always #5 clk = ~clk;

  tick_countdown #(.START_VAL(8'h09), .AUTO_RELOAD(1'b0)) u0 (
    .clki(clk), .rst(rst), .tick(tick), .start(start),
    .pause(pause), .load(load), .load_val(load_val),
    .bcd_tens(bt[0]), .bcd_ones(bo[0]),
    .seg_tens(st[0]), .seg_ones(so[0]),
    .running(rn[0]), .done(dn[0])
  );

  tick_countdown #(.START_VAL(8'h09), .AUTO_RELOAD(1'b1)) u1 (
    .clki(clk), .rst(rst), .tick(tick), .start(start),
    .pause(pause), .load(load), .load_val(load_val),
    .bcd_tens(bt[1]), .bcd_ones(bo[1]),
    .seg_tens(st[1]), .seg_ones(so[1]),
    .running(rn[1]), .done(dn[1])
  );

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic mstep(input int i, input bit ar);
    int c;
    bit d;
    c = mcnt[i];
    d = 1'b0;
    case (mst[i])
      0: begin
        if (load && load_val[7:4] <= 9 && load_val[3:0] <= 9) begin
          c = 10 * int'(load_val[7:4]) + int'(load_val[3:0]);
          mrel[i] = c;
        end
        if (start) begin
          if (c == 0) d = 1'b1;
          else mst[i] = 1;
        end
      end
      1: begin
        if (pause) mst[i] = 2;
        else if (tick) begin
          if (c == 0) c = mrel[i];
          else begin
            c = c - 1;
            if (c == 0) begin
              d = 1'b1;
              if (!ar) mst[i] = 0;
            end
          end
        end
      end
      default: if (start) mst[i] = 1;
    endcase
    mcnt[i] = c;
    mdone[i] = d;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mcnt[i] = 9;
        mrel[i] = 9;
        mst[i] = 0;
        mdone[i] = 1'b0;
      end
    end else begin
      mstep(0, 1'b0);
      mstep(1, 1'b1);
    end
  end

  always @(negedge clk) begin
    if (dn[0]) dpulses++;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("m%0d_tens", i), int'(bt[i]), mcnt[i] / 10);
      chk($sformatf("m%0d_ones", i), int'(bo[i]), mcnt[i] % 10);
      chk($sformatf("m%0d_segt", i), int'(st[i]),
          int'(seg_of(mcnt[i] / 10)));
      chk($sformatf("m%0d_sego", i), int'(so[i]),
          int'(seg_of(mcnt[i] % 10)));
      chk($sformatf("m%0d_run", i), int'(rn[i]), int'(mst[i] == 1));
      chk($sformatf("m%0d_done", i), int'(dn[i]), int'(mdone[i]));
    end
  end

  task automatic step(input bit t, input bit s, input bit p,
                      input bit l, input logic [7:0] v);
    @(negedge clk);
    tick = t;
    start = s;
    pause = p;
    load = l;
    load_val = v;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 8'h00);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    tick = 0; start = 0; pause = 0; load = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int cnt(input int i);
    return 10 * int'(bt[i]) + int'(bo[i]);
  endfunction

  initial begin
    int d0;
    int seq [4];
    seq[0] = 1; seq[1] = 0; seq[2] = 2; seq[3] = 1;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    settle();
    chk("rst_cnt", cnt(0), 9);
    chk("rst_run", int'(rn[0]), 0);
    chk("rst_done", int'(dn[0]), 0);
    chk("rst_sego", int'(so[0]), 'h10);
    chk("rst_segt", int'(st[0]), 'h40);

    // 9 ticks spaced 5 cycles
    step(0, 1, 0, 0, 8'h00);
    settle();
    chk("start_run", int'(rn[0]), 1);
    d0 = dpulses;
    for (int k = 1; k <= 9; k++) begin
      idle(4);
      step(1, 0, 0, 0, 8'h00);
      settle();
      chk("dn_cnt", cnt(0), 9 - k);
    end
    chk("tc_done", int'(dn[0]), 1);
    chk("tc_idle", int'(rn[0]), 0);
    idle(1);
    settle();
    chk("tc_done_off", int'(dn[0]), 0);
    idle(2);
    chk("tc_once", dpulses - d0, 1);

    // tens borrow
    step(0, 0, 0, 1, 8'h20);
    step(0, 1, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00);
    settle();
    chk("b_cnt", cnt(0), 19);
    chk("b_sego", int'(so[0]), 7'b0010000);
    chk("b_segt", int'(st[0]), 7'b1111001);

    // pause wins over tick
    for (int k = 0; k < 14; k++) step(1, 0, 0, 0, 8'h00);
    settle();
    chk("p_at5", cnt(0), 5);
    step(1, 0, 1, 0, 8'h00);
    settle();
    chk("p_hold", cnt(0), 5);
    chk("p_run", int'(rn[0]), 0);
    for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 8'h00);
    settle();
    chk("p_ign", cnt(0), 5);
    step(0, 1, 0, 0, 8'h00);
    settle();
    chk("p_resume", int'(rn[0]), 1);
    step(1, 0, 0, 0, 8'h00);
    settle();
    chk("p_next", cnt(0), 4);
    step(0, 0, 0, 1, 8'h15);
    settle();
    chk("ld_run_ign", cnt(0), 4);

    // auto reload
    do_reset();
    step(0, 0, 0, 1, 8'h02);
    step(0, 1, 0, 0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      step(1, 0, 0, 0, 8'h00);
      settle();
      chk("ar_cnt", cnt(1), seq[k]);
      chk("ar_run", int'(rn[1]), 1);
      if (k == 1) chk("ar_done", int'(dn[1]), 1);
    end

    // invalid load in IDLE (u0 sits at 00)
    step(0, 0, 0, 1, 8'h1A);
    settle();
    chk("ld_bad", cnt(0), 0);

    // async reset mid-count
    step(0, 0, 0, 1, 8'h05);
    step(0, 1, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    @(posedge clk);
    #1;
    chk("ar_at3", cnt(0), 3);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_cnt", cnt(0), 9);
    chk("arst_run", int'(rn[0]), 0);
    chk("arst_done", int'(dn[0]), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // random
    for (int n = 0; n < 4000; n++) begin
      logic [7:0] v;
      if ($urandom_range(0, 3) == 0) v = 8'($urandom);
      else v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 2) == 0,
             $urandom_range(0, 7) == 0,
             $urandom_range(0, 15) == 0,
             $urandom_range(0, 11) == 0, v);
      end
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_countdown.md
# tick_countdown

Two-digit BCD down-counter that consumes the single-cycle `tick` strobe produced by the clock divider and counts one step per tick. It is the timing-display end of the divider interface: it owns start/pause/load control, detects terminal count, and drives two active-low seven-segment digits. It sits between the divider and the board display pins in the countdown designs.

## Interface
- `START_VAL`, default 8'h09: BCD value loaded at reset and on auto-reload; each nibble must be 0..9.
- `AUTO_RELOAD`, default 0: 1 means reload the last loaded value at terminal count and keep running; 0 means stop in IDLE.

Ports:
- `clki` in 1: system clock, all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `tick` in 1: one-`clki`-cycle strobe from the divider; level is never interpreted, only sampled per cycle.
- `start` in 1: begin or resume counting.
- `pause` in 1: freeze the count while running.
- `load` in 1: capture `load_val` as the new count and reload value.
- `load_val` in 8: BCD {tens, ones}.
- `bcd_tens` out 4, `bcd_ones` out 4: registered current count.
- `seg_tens` out 7, `seg_ones` out 7: active-low segments {g,f,e,d,c,b,a}.
- `running` out 1: high in RUN.
- `done` out 1: one-cycle pulse at terminal count.

## Operation
- States: IDLE, RUN, PAUSED. Registers: count, reload_val, state, done.
- Reset, asynchronous: state IDLE, count = reload_val = START_VAL, done 0, running 0.
- IDLE:
  - `load` with both nibbles ≤ 9 sets count and reload_val to `load_val`.
  - Invalid BCD on `load` is ignored, with no change.
  - `start` goes to RUN.
  - `load` and `start` in the same cycle: the load takes effect and the state goes to RUN with the new value.
  - `start` with count == 00 pulses `done` and stays in IDLE.
- RUN:
  - `tick` decrements count in BCD: if ones == 0, ones becomes 9 and tens decrements; otherwise ones decrements.
  - When a tick takes count from 01 to 00, `done` pulses the next cycle.
  - After that transition, with AUTO_RELOAD = 0: go to IDLE holding 00.
  - With AUTO_RELOAD = 1: stay in RUN. The next tick loads reload_val instead of decrementing, so 00 is displayed for one full tick period.
  - `pause` goes to PAUSED. `pause` with `tick` in the same cycle: pause wins and the tick is dropped, count unchanged.
  - `load` and `start` are ignored.
- PAUSED:
  - Ticks are ignored.
  - `start` returns to RUN.
  - `start` with `tick` in the same cycle resumes but does not decrement that cycle.
  - `pause`, `load` and redundant `start` inputs have no effect beyond this.
- Reset mid-count returns immediately to START_VAL and IDLE. The value from any earlier `load` is lost.
- Segment decode is combinational from the registered BCD values. Nibbles above 9 are unreachable; if one occurs, the decoder shows blank (7'h7F).

## Timing
- Every state and count update happens on the `clki` edge that samples the control or `tick` high. `bcd_*` and `running` are valid the following cycle; `seg_*` follows one combinational delay later.
- `done` is registered: it is high for exactly one cycle, the cycle after the edge that produced 00.
- Control inputs are assumed synchronous to `clki`; no synchronizers are inside the block.
- There is no minimum spacing between ticks: back-to-back ticks on consecutive cycles each decrement.

## Structure
- Shared package/include holds:
  - the state encoding constants (IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2);
  - the BCD digit width of 4;
  - the seven-segment patterns for 0–9 and blank.
- One sub-module, `seg7_decode`: 4-bit BCD in, 7-bit active-low segments out, purely combinational. It is instantiated twice.
- The BCD decrement stays inline in `tick_countdown`.

## Test plan
- Reset, then `start`, then 9 ticks spaced 5 cycles apart: count goes 09, 08 … 00; `done` is high exactly once, the cycle after the ninth tick edge; state returns to IDLE.
- `load` 8'h20, `start`, 1 tick: count is 19 (ones wrap to 9, tens decrement); `seg_ones` = 7'b0010000, `seg_tens` = 7'b1111001.
- Running at 05, assert `pause` and `tick` in the same cycle: count stays 05; further ticks are ignored; `start` resumes and the next tick gives 04.
- `load` 8'h1A while in IDLE: ignored, count unchanged. `load` 8'h15 while in RUN: ignored.
- AUTO_RELOAD = 1, `load` 8'h02, `start`, 4 ticks: count goes 01, 00 (with `done` pulse), 02, 01; `running` stays high throughout.
- Assert `rst` asynchronously between clock edges while running at 03: outputs go to 09, `running` 0, `done` 0 without waiting for an edge.
